// File: rtl/conv_layer_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module : conv_layer_input_scheduler
// Walks the input ROM row-major, fills the K-row pixel cache and releases one
// output row of convolution windows at a time through a ready/ack handshake.
// Rev    : 1.0
// ============================================================================
module conv_layer_input_scheduler #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 6,
  parameter int COL_W  = 3,
  parameter int ROW_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              row_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              cache_wr,
  output logic [COL_W-1:0]  cache_col,
  output logic              row_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic              busy,
  output logic              done,
  output logic [2:0]        current_state
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_preload = 3'd1;
  localparam logic [2:0] c_st_ready   = 3'd2;
  localparam logic [2:0] c_st_load    = 3'd3;
  localparam logic [2:0] c_st_done    = 3'd4;

  localparam logic [ADDR_W-1:0] c_preload_last = ADDR_W'(K * IMG_W - 1);
  localparam logic [ADDR_W-1:0] c_last_addr    = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  c_last_col     = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  c_last_row     = ROW_W'(IMG_H - K);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              fetch_last;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    fetch_last = 1'b0;
    case (state_q)
      c_st_idle: begin
        rom_addr_d = '0;
        col_d      = '0;
        row_d      = '0;
        if (start) state_d = c_st_preload;
      end
      c_st_preload, c_st_load: begin
        if (!stall) begin
          // The address saturates so the final write of a frame leaves it at the last pixel.
          rom_addr_d = (rom_addr_q == c_last_addr) ? rom_addr_q : rom_addr_q + ADDR_W'(1);
          col_d      = (col_q == c_last_col) ? '0 : col_q + COL_W'(1);
          fetch_last = (state_q == c_st_preload) ? (rom_addr_q == c_preload_last)
                                                 : (col_q == c_last_col);
          if (fetch_last) state_d = c_st_ready;
        end
      end
      c_st_ready: begin
        if (row_ack) begin
          if (row_q == c_last_row) begin
            state_d = c_st_done;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = c_st_load;
          end
        end
      end
      default: begin
        // Covers DONE and the unused codes: clear the walk and return to IDLE.
        rom_addr_d = '0;
        col_d      = '0;
        row_d      = '0;
        state_d    = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      rom_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign cache_wr      = ((state_q == c_st_preload) || (state_q == c_st_load)) && !stall;
  assign row_ready     = (state_q == c_st_ready);
  assign busy          = (state_q != c_st_idle);
  assign done          = (state_q == c_st_done);
  assign rom_addr      = rom_addr_q;
  assign cache_col     = col_q;
  assign out_row       = row_q;
  assign current_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_layer_input_scheduler
// Directed bench with a pixel/row-count model checked every cycle.
// Rev    : 1.0
// ============================================================================
module tb_conv_layer_input_scheduler;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 8;
  localparam int K        = 3;
  localparam int LAST_ROW = IMG_H - K;
  localparam int NPIX     = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst, start, stall, row_ack;
  logic [5:0] rom_addr;
  logic       cache_wr;
  logic [2:0] cache_col;
  logic       row_ready;
  logic [2:0] out_row;
  logic       busy, done;
  logic [2:0] current_state;

  conv_layer_input_scheduler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(6), .COL_W(3), .ROW_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .row_ack(row_ack),
    .rom_addr(rom_addr), .cache_wr(cache_wr), .cache_col(cache_col),
    .row_ready(row_ready), .out_row(out_row), .busy(busy), .done(done),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0, rdy_phases = 0, done_count = 0;
  bit prev_rdy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is "pixels fetched so far" and "rows acknowledged so far".
  bit m_valid = 1'b0;
  bit m_active = 1'b0;
  int m_writes = 0;
  int m_acks = 0;

  function automatic bit m_in_done();
    return m_active && (m_acks == LAST_ROW + 1);
  endfunction
  function automatic int m_target();
    return (K + m_acks) * IMG_W;
  endfunction
  function automatic bit m_ready();
    return m_active && !m_in_done() && (m_writes == m_target());
  endfunction
  function automatic bit m_fetch();
    return m_active && !m_in_done() && (m_writes < m_target());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_writes = 0; m_acks = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1'b1; m_writes = 0; m_acks = 0; end
    end else if (m_in_done()) begin
      m_active = 1'b0;
    end else if (m_fetch()) begin
      if (!stall) m_writes++;
    end else if (m_ready() && row_ack) begin
      m_acks++;
    end
  end

  always @(negedge clk) begin
    int e_addr, e_col, e_row, e_state;
    if (m_valid) begin
      e_addr  = m_active ? ((m_writes > NPIX - 1) ? NPIX - 1 : m_writes) : 0;
      e_col   = m_active ? (m_writes % IMG_W) : 0;
      e_row   = m_active ? ((m_acks > LAST_ROW) ? LAST_ROW : m_acks) : 0;
      e_state = !m_active ? 0 : m_in_done() ? 4 : m_ready() ? 2 : (m_acks == 0) ? 1 : 3;
      check("m_rom_addr",  int'(rom_addr),  e_addr);
      check("m_cache_col", int'(cache_col), e_col);
      check("m_out_row",   int'(out_row),   e_row);
      check("m_cache_wr",  int'(cache_wr),  int'(m_fetch() && !stall));
      check("m_row_ready", int'(row_ready), int'(m_ready()));
      check("m_busy",      int'(busy),      int'(m_active));
      check("m_done",      int'(done),      int'(m_in_done()));
      check("m_state",     int'(current_state), e_state);
      if (cache_wr === 1'b1) wr_count++;
      if (row_ready === 1'b1 && !prev_rdy) rdy_phases++;
      if (done === 1'b1) done_count++;
      prev_rdy = (row_ready === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  int'(rom_addr), 0);
    check({tag, "_col"},   int'(cache_col), 0);
    check({tag, "_row"},   int'(out_row), 0);
    check({tag, "_wr"},    int'(cache_wr), 0);
    check({tag, "_rdy"},   int'(row_ready), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_state"}, int'(current_state), 0);
  endtask

  // Unstalled frame with ack always asserted; called while the DUT is idle.
  task automatic run_clean_frame(input string tag);
    int n, first_rdy, done_cyc;
    wr_count = 0; rdy_phases = 0; done_count = 0;
    row_ack = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 1; first_rdy = 0; done_cyc = 0;
    while (done_cyc == 0 && n < 300) begin
      if (row_ready === 1'b1 && first_rdy == 0) first_rdy = n;
      if (done === 1'b1) done_cyc = n;
      if (done_cyc == 0) begin step(); n++; end
    end
    check({tag, "_first_ready_cycle"}, first_rdy, 25);
    check({tag, "_done_cycle"}, done_cyc, 71);
    check({tag, "_writes"}, wr_count, 64);
    check({tag, "_ready_phases"}, rdy_phases, 6);
    check({tag, "_last_addr_in_done"}, int'(rom_addr), 63);
    step();
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_pulses"}, done_count, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stall = 1'b0; row_ack = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full frame followed by a back-to-back frame started the cycle after done.
    run_clean_frame("frame1");
    run_clean_frame("frame2");

    // Stall in PRELOAD, ack pulsed in PRELOAD, delayed ack, start pulsed in LOAD.
    wr_count = 0; rdy_phases = 0; done_count = 0;
    row_ack = 1'b0; start = 1'b1;
    step(); start = 1'b0; n = 1;
    row_ack = 1'b1; step(); n++; row_ack = 1'b0;
    while (rom_addr !== 6'd10 && n < 100) begin step(); n++; end
    check("stall_reach_cycle", n, 11);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_addr_hold", int'(rom_addr), 10);
      check("stall_no_write", int'(cache_wr), 0);
      step(); n++;
    end
    stall = 1'b0;
    check("stall_addr_after", int'(rom_addr), 10);
    while (row_ready !== 1'b1 && n < 100) begin step(); n++; end
    check("stall_ready_cycle", n, 28);
    for (int i = 0; i < 10; i++) begin
      check("hold_ready", int'(row_ready), 1);
      check("hold_addr", int'(rom_addr), 24);
      check("hold_no_write", int'(cache_wr), 0);
      if (i == 9) row_ack = 1'b1;
      step();
    end
    row_ack = 1'b0;
    check("after_ack_state", int'(current_state), 3);
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    check("start_in_load_state", int'(current_state), 3);
    check("start_in_load_addr", int'(rom_addr), 27);
    row_ack = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 300) begin step(); n++; end
    check("stall_frame_done", int'(done), 1);
    check("stall_frame_writes", wr_count, 64);
    check("stall_frame_phases", rdy_phases, 6);
    step();

    // Reset mid-LOAD, then a fresh frame from address 0.
    done_count = 0;
    row_ack = 1'b1; start = 1'b1;
    step(); start = 1'b0; n = 0;
    while (rom_addr !== 6'd37 && n < 200) begin step(); n++; end
    check("midload_state", int'(current_state), 3);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset_outputs("midrst");
    step(); step(); step();
    check("midrst_no_done", done_count, 0);
    run_clean_frame("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/conv_layer_input_scheduler.md
# conv_layer_input_scheduler

Sequencer for the conv-layer input pixel cache: walks the input feature-map ROM in row-major order, drives the ROM address and the cache write strobes, and releases one output row of convolution windows at a time to the downstream kernel array through a ready/ack handshake. It sits between the 64x32 input ROM, the pixel cache and the conv-layer top-level control. It also honours a downstream stall so the cache never overwrites data still in use.

## Interface
- IMG_W, 8, input feature-map width in pixels
- IMG_H, 8, input feature-map height in pixels
- K, 3, kernel size (rows held in cache)
- ADDR_W, 6, ROM address width; 2^ADDR_W >= IMG_W*IMG_H
- COL_W, 3, column index width, $clog2(IMG_W)
- ROW_W, 3, output-row index width, holds IMG_H-K

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- stall  in  1  downstream busy; suspends fetch in PRELOAD/LOAD
- row_ack  in  1  downstream consumed current window row; sampled only in READY
- rom_addr  out  ADDR_W  ROM read address (ROM is asynchronous, data valid same cycle)
- cache_wr  out  1  cache captures ROM data at this edge
- cache_col  out  COL_W  column slot for the current write
- row_ready  out  1  K rows resident; window row valid at cache output
- out_row  out  ROW_W  index of the output row being presented (0..IMG_H-K)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle frame-complete pulse
- current_state  out  3  state encoding, for debug

## Operation
- States: IDLE=0, PRELOAD=1, READY=2, LOAD=3, DONE=4; codes 5-7 go to IDLE next cycle.
- IDLE: rom_addr, cache_col, out_row held at 0. start=1 -> PRELOAD.
- PRELOAD: fetches K*IMG_W pixels (addresses 0..23 at defaults). Each cycle with stall=0: cache_wr=1, then rom_addr+1, cache_col+1 (wraps IMG_W-1 -> 0). The write at address K*IMG_W-1 -> READY.
- READY: row_ready=1 and held until row_ack=1. On ack: if out_row==IMG_H-K -> DONE, otherwise out_row+1 -> LOAD. stall is ignored in READY.
- LOAD: fetches IMG_W pixels, one new row, with the same stall/increment rules as PRELOAD. The write with cache_col==IMG_W-1 -> READY.
- DONE: done=1 for one cycle; rom_addr, cache_col, out_row cleared -> IDLE.
- Decoding: cache_wr = (PRELOAD|LOAD) & ~stall. row_ready = READY. busy = ~IDLE. done = DONE. All decoded combinationally from state.
- rom_addr, cache_col, out_row and state are registered.
- rom_addr never exceeds IMG_W*IMG_H-1; the last write of a frame is at address 63.

## Timing
- Reset: state=IDLE; rom_addr=0, cache_col=0, out_row=0; cache_wr=row_ready=busy=done=0; current_state=0.
- Reset mid-operation: abandon the frame, same values as above, no done pulse.
- Latency: start sampled at edge 0. Writes occur at edges 1..24. row_ready is first high in cycle 25.
- Each ack not on the last row: exactly IMG_W write cycles (if unstalled), then row_ready again.
- Stall: each stalled cycle adds exactly one cycle. rom_addr and cache_col hold and no write occurs.
- start outside IDLE is ignored. row_ack outside READY is ignored.
- row_ack in the same cycle row_ready rises is accepted; state leaves READY at the next edge.
- Frame total: IMG_H-K+1 = 6 row_ready phases and IMG_W*IMG_H = 64 writes.
- A start in the cycle after DONE (state IDLE) begins a new frame from address 0.

## Test plan
- Full frame, no stall, immediate ack:
  - writes at addresses 0..23 with cache_col cycling 0..7 x3, then row_ready in cycle 25.
  - After each ack, 8 writes; 6 row_ready pulses with out_row 0..5, 64 writes total.
  - done one cycle after the 6th ack; busy then drops.
- Stall 3 cycles while rom_addr=10 in PRELOAD: rom_addr holds 10 and cache_wr=0 for 3 cycles; row_ready rises in cycle 28.
- Delayed ack, 10 cycles in READY: row_ready held high for 10 cycles, rom_addr stable at 24, no writes.
- start pulsed during LOAD and row_ack pulsed during PRELOAD: no effect on state, address or counts.
- rst asserted mid-LOAD at rom_addr=37:
  - next cycle all outputs are at reset values; done is never pulsed.
  - A following start restarts from address 0.
- Back-to-back frames, start in the cycle after done: the second frame repeats the scenario-1 sequence exactly.
